recip_core_multi: RTL and testbench
===================================

// Module: recip_core_multi
// PURPOSE
//   Multi-channel successor to the single-sensor N-period reciprocal counter: NUM_CH async sensors,
//   each with its own synchroniser, edge detector, period FSM and coarse counter, all in clk_fast.
//   Run-time N (cfg_n_cycles), optional timeout for stalled sensors, abort on enable drop.
//   Results are merged by a round-robin arbiter onto one valid/ready stream for the CDC/readout stage.
// PARAMETERS
//   NUM_CH        4   number of sensor channels (1..16)
//   COARSE_WIDTH 24   coarse clk_fast period count width
//   EDGE_WIDTH   16   width of cfg_n_cycles and the edge counter
//   SYNC_STAGES   2   synchroniser flops per sensor input (>=2)
// PORTS
//   clk_fast      in   1               measurement clock (50 MHz today, PLL output later)
//   rst_n         in   1               asynchronous reset, active-low
//   enable        in   1               1 = channels may arm; 0 = abort in-flight measurements
//   sensor_in     in   NUM_CH          asynchronous sensor inputs
//   cfg_n_cycles  in   EDGE_WIDTH      N rising edges per measurement; sampled at each start
//   cfg_timeout   in   COARSE_WIDTH    max coarse count before a forced stop; 0 = disabled
//   ch_busy       out  NUM_CH          channel is in MEASURE
//   res_valid     out  1               result available
//   res_ready     in   1               consumer accepts result
//   res_ch        out  CH_W            originating channel, CH_W = max(1,clog2(NUM_CH))
//   res_coarse    out  COARSE_WIDTH    clk_fast cycles from start edge to stop edge
//   res_edges     out  EDGE_WIDTH      rising edges counted, start edge included
//   res_timeout   out  1               measurement ended by timeout or saturation
// BEHAVIOUR
//   Reset: all outputs are 0. Every channel goes to IDLE, all counters clear, and the arbiter pointer is 0.
//   Edge pulse: 1-cycle pulse SYNC_STAGES+1 cycles after a sensor rising edge; glitches shorter than 1 clk are not guaranteed.
//   Effective N: n_eff = max(cfg_n_cycles,2), latched at start. It is not affected by later cfg changes.
//   Per-channel FSM:
//     IDLE    -> ARMED   when enable=1.
//     ARMED   -> MEASURE on an edge pulse. On that cycle: edges=1, coarse=0.
//     MEASURE: coarse increments every cycle. Each edge pulse increments edges.
//              An edge pulse making edges==n_eff -> HOLD. The stored coarse includes the stop cycle increment.
//     Timeout: if cfg_timeout!=0 and coarse reaches cfg_timeout -> HOLD with timeout=1.
//              Stored coarse = cfg_timeout; stored edges = edges seen so far.
//     Saturation: coarse reaching all-ones -> HOLD with timeout=1, even if cfg_timeout=0.
//     Same cycle as an N-th edge and a timeout: the edge wins, timeout=0.
//     HOLD: result is frozen. The channel ignores edges and does not re-arm until the arbiter grants it.
//     Grant -> ARMED if enable=1, else IDLE.
//     enable=0 in ARMED or MEASURE -> IDLE next cycle; no result, and ch_busy drops.
//     enable=0 does not discard results already held in HOLD.
//   Exact count: for a periodic sensor of period P clocks, coarse = (n_eff-1)*P.
//   Arbiter/output register:
//     When the output is empty (res_valid=0, or the current result is accepted this cycle), grant the
//     first HOLD channel at or after ptr, wrapping. Then ptr = granted+1 mod NUM_CH.
//     The result is registered: res_valid rises the cycle after grant, so minimum stop-to-valid latency is 2 cycles.
//     res_* are stable while res_valid && !res_ready. Back-to-back transfers sustain one per cycle.
//     Only one channel is granted per cycle. Other HOLD channels wait, and no result is ever dropped or duplicated.
//   Async reset mid-measurement clears everything immediately; in-flight results are lost.
// STRUCTURE
//   Package recip_pkg:
//     channel state enum {IDLE, ARMED, MEASURE, HOLD} as localparams.
//     clog2-based CH_W function.
//     result record field widths.
//   Sub-module recip_channel, instantiated NUM_CH times via generate. It holds:
//     the synchroniser chain, edge detect, FSM, coarse/edge counters and result regs;
//     a hold output plus a grant input.
//   The top level holds the round-robin arbiter and the output register only.
// TESTING
//   1. NUM_CH=4, cfg_n=4, ch0 period 10 clk -> one result: ch=0, coarse=30, edges=4, timeout=0.
//   2. ch0..3 all stop in the same cycle, res_ready=1 -> results on 4 consecutive cycles, order 0,1,2,3.
//      Repeat from ptr=2 -> order 2,3,0,1.
//   3. cfg_timeout=100, ch1 sensor stops after 3 edges -> ch=1, coarse=100, edges=3, timeout=1.
//   4. Backpressure: res_ready=0 for 20 cycles while 2 channels finish -> outputs are held stable.
//      After res_ready=1 both results are delivered, and the channels re-arm only after their grant.
//   5. cfg_n=0 and cfg_n=1 -> both behave as n_eff=2; period 7 gives coarse=7.
//      Change cfg_n mid-measure -> the latched value is used.
//   6. enable=0 mid-MEASURE -> no result and ch_busy=0 next cycle.
//      rst_n pulse mid-transfer -> all outputs are 0 asynchronously.

Source files
------------

// File: rtl/recip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : recip_pkg
//  Description : Shared types, default widths and helpers for the
//                multi-channel N-period reciprocal counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package recip_pkg;

    // Per-channel measurement state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_HOLD    = 2'd3
    } ch_state_e;

    // Default result record field widths
    localparam int DEF_COARSE_WIDTH = 24;
    localparam int DEF_EDGE_WIDTH   = 16;
    localparam int DEF_SYNC_STAGES  = 2;

    // Channel index width; a single channel still needs one bit
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/recip_channel.sv
`default_nettype none
// ============================================================================
//  Module      : recip_channel
//  Description : One sensor channel: synchroniser, rising-edge detector,
//                period FSM, coarse/edge counters and held result.
//  Revision    : 1.0 - initial release
// ============================================================================
module recip_channel
    import recip_pkg::*;
#(
    parameter int COARSE_WIDTH = DEF_COARSE_WIDTH,
    parameter int EDGE_WIDTH   = DEF_EDGE_WIDTH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    sensor_in,
    input  logic [EDGE_WIDTH-1:0]   cfg_n_cycles,
    input  logic [COARSE_WIDTH-1:0] cfg_timeout,
    input  logic                    grant,
    output logic                    busy,
    output logic                    hold,
    output logic [COARSE_WIDTH-1:0] res_coarse,
    output logic [EDGE_WIDTH-1:0]   res_edges,
    output logic                    res_timeout
);

    logic [SYNC_STAGES-1:0]  sync_q,    sync_d;
    logic                    prev_q,    prev_d;
    logic                    pulse_q,   pulse_d;
    ch_state_e               state_q,   state_d;
    logic [COARSE_WIDTH-1:0] coarse_q,  coarse_d;
    logic [EDGE_WIDTH-1:0]   edges_q,   edges_d;
    logic [EDGE_WIDTH-1:0]   n_eff_q,   n_eff_d;
    logic                    timeout_q, timeout_d;

    logic [COARSE_WIDTH-1:0] coarse_inc;
    logic [EDGE_WIDTH-1:0]   edges_inc;

    // Synchroniser shift and registered single-cycle rising-edge pulse
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sensor_in};
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Measurement FSM: start edge arms counters, N-th edge / timeout / saturation stop
    always_comb begin
        state_d    = state_q;
        coarse_d   = coarse_q;
        edges_d    = edges_q;
        n_eff_d    = n_eff_q;
        timeout_d  = timeout_q;
        coarse_inc = coarse_q + 1'b1;
        edges_inc  = edges_q + {{(EDGE_WIDTH-1){1'b0}}, pulse_q};
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (pulse_q) begin
                    state_d   = ST_MEASURE;
                    coarse_d  = '0;
                    edges_d   = EDGE_WIDTH'(1);
                    timeout_d = 1'b0;
                    // N below 2 cannot bound a period, so it is promoted
                    n_eff_d   = (cfg_n_cycles < EDGE_WIDTH'(2)) ? EDGE_WIDTH'(2) : cfg_n_cycles;
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    coarse_d = coarse_inc;
                    edges_d  = edges_inc;
                    // The N-th edge takes priority over a coincident timeout
                    if (pulse_q && (edges_inc == n_eff_q)) begin
                        state_d   = ST_HOLD;
                        timeout_d = 1'b0;
                    end else if ((cfg_timeout != '0) && (coarse_inc >= cfg_timeout)) begin
                        state_d   = ST_HOLD;
                        timeout_d = 1'b1;
                        coarse_d  = cfg_timeout;
                    end else if (&coarse_inc) begin
                        state_d   = ST_HOLD;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (grant) state_d = enable ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            pulse_q   <= 1'b0;
            state_q   <= ST_IDLE;
            coarse_q  <= '0;
            edges_q   <= '0;
            n_eff_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pulse_q   <= pulse_d;
            state_q   <= state_d;
            coarse_q  <= coarse_d;
            edges_q   <= edges_d;
            n_eff_q   <= n_eff_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy        = (state_q == ST_MEASURE);
    assign hold        = (state_q == ST_HOLD);
    assign res_coarse  = coarse_q;
    assign res_edges   = edges_q;
    assign res_timeout = timeout_q;

endmodule
`default_nettype wire

// File: rtl/recip_core_multi.sv
`default_nettype none
// ============================================================================
//  Module      : recip_core_multi
//  Description : NUM_CH reciprocal-counter channels merged onto a single
//                valid/ready result stream by a round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module recip_core_multi
    import recip_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int COARSE_WIDTH = DEF_COARSE_WIDTH,
    parameter int EDGE_WIDTH   = DEF_EDGE_WIDTH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                    clk_fast,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       sensor_in,
    input  logic [EDGE_WIDTH-1:0]   cfg_n_cycles,
    input  logic [COARSE_WIDTH-1:0] cfg_timeout,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CH_W-1:0]         res_ch,
    output logic [COARSE_WIDTH-1:0] res_coarse,
    output logic [EDGE_WIDTH-1:0]   res_edges,
    output logic                    res_timeout
);

    logic [NUM_CH-1:0]                   ch_hold;
    logic [NUM_CH-1:0]                   grant;
    logic [NUM_CH-1:0][COARSE_WIDTH-1:0] ch_coarse;
    logic [NUM_CH-1:0][EDGE_WIDTH-1:0]   ch_edges;
    logic [NUM_CH-1:0]                   ch_timeout;

    logic [CH_W-1:0]         ptr_q,         ptr_d;
    logic                    res_valid_q,   res_valid_d;
    logic [CH_W-1:0]         res_ch_q,      res_ch_d;
    logic [COARSE_WIDTH-1:0] res_coarse_q,  res_coarse_d;
    logic [EDGE_WIDTH-1:0]   res_edges_q,   res_edges_d;
    logic                    res_timeout_q, res_timeout_d;

    logic                    out_free;
    logic                    found;
    logic [CH_W-1:0]         gnt_idx;
    int                      idx;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            recip_channel #(
                .COARSE_WIDTH (COARSE_WIDTH),
                .EDGE_WIDTH   (EDGE_WIDTH),
                .SYNC_STAGES  (SYNC_STAGES)
            ) u_ch (
                .clk          (clk_fast),
                .rst_n        (rst_n),
                .enable       (enable),
                .sensor_in    (sensor_in[g]),
                .cfg_n_cycles (cfg_n_cycles),
                .cfg_timeout  (cfg_timeout),
                .grant        (grant[g]),
                .busy         (ch_busy[g]),
                .hold         (ch_hold[g]),
                .res_coarse   (ch_coarse[g]),
                .res_edges    (ch_edges[g]),
                .res_timeout  (ch_timeout[g])
            );
        end
    endgenerate

    // Round-robin grant of one holding channel whenever the output slot frees up
    always_comb begin
        out_free      = !res_valid_q || res_ready;
        found         = 1'b0;
        gnt_idx       = '0;
        idx           = 0;
        grant         = '0;
        ptr_d         = ptr_q;
        res_valid_d   = res_valid_q;
        res_ch_d      = res_ch_q;
        res_coarse_d  = res_coarse_q;
        res_edges_d   = res_edges_q;
        res_timeout_d = res_timeout_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && out_free && ch_hold[idx]) begin
                found   = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
        if (found) begin
            grant[gnt_idx] = 1'b1;
            ptr_d          = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            res_valid_d    = 1'b1;
            res_ch_d       = gnt_idx;
            res_coarse_d   = ch_coarse[gnt_idx];
            res_edges_d    = ch_edges[gnt_idx];
            res_timeout_d  = ch_timeout[gnt_idx];
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Arbiter pointer and registered output slot
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_coarse_q  <= '0;
            res_edges_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            res_valid_q   <= res_valid_d;
            res_ch_q      <= res_ch_d;
            res_coarse_q  <= res_coarse_d;
            res_edges_q   <= res_edges_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_coarse  = res_coarse_q;
    assign res_edges   = res_edges_q;
    assign res_timeout = res_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_recip_core_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_recip_core_multi
//  Description : Directed self-checking bench for recip_core_multi with a
//                result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_recip_core_multi;

    localparam int NUM_CH = 4;
    localparam int CW     = 24;
    localparam int EW     = 16;

    typedef struct {
        logic [1:0]    ch;
        logic [CW-1:0] coarse;
        logic [EW-1:0] edges;
        logic          to;
    } exp_t;

    logic              clk_fast;
    logic              rst_n;
    logic              enable;
    logic [NUM_CH-1:0] sensor_in;
    logic [EW-1:0]     cfg_n_cycles;
    logic [CW-1:0]     cfg_timeout;
    logic [NUM_CH-1:0] ch_busy;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_ch;
    logic [CW-1:0]     res_coarse;
    logic [EW-1:0]     res_edges;
    logic              res_timeout;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    recip_core_multi #(
        .NUM_CH       (NUM_CH),
        .COARSE_WIDTH (CW),
        .EDGE_WIDTH   (EW),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_fast     (clk_fast),
        .rst_n        (rst_n),
        .enable       (enable),
        .sensor_in    (sensor_in),
        .cfg_n_cycles (cfg_n_cycles),
        .cfg_timeout  (cfg_timeout),
        .ch_busy      (ch_busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_ch       (res_ch),
        .res_coarse   (res_coarse),
        .res_edges    (res_edges),
        .res_timeout  (res_timeout)
    );

    initial begin
        clk_fast = 1'b0;
        forever #5 clk_fast = ~clk_fast;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    // Half a period high (already raised by caller), then low for the rest
    task automatic gap(input logic [NUM_CH-1:0] mask, input int p);
        repeat (p / 2) tick();
        sensor_in = sensor_in & ~mask;
        repeat (p - p / 2) tick();
    endtask

    // n rising edges p cycles apart; returns right after the last rise
    task automatic train(input logic [NUM_CH-1:0] mask, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            sensor_in = sensor_in | mask;
            if (k < n - 1) gap(mask, p);
        end
    endtask

    task automatic push(input int ch, input int coarse, input int edges, input int to);
        exp_t e;
        e.ch     = 2'(ch);
        e.coarse = CW'(coarse);
        e.edges  = EW'(edges);
        e.to     = to[0];
        sb.push_back(e);
    endtask

    // Wait for a handshake, compare it with the scoreboard head, step past it
    task automatic wait_result(input string tag, input int budget, output int waited);
        logic got;
        exp_t e;
        got    = 1'b0;
        waited = 0;
        for (int c = 0; c < budget; c++) begin
            if (res_valid && res_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
            tick();
        end
        chk({tag, "_arrived"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_ch"},      64'(res_ch),      64'(e.ch));
                chk({tag, "_coarse"},  64'(res_coarse),  64'(e.coarse));
                chk({tag, "_edges"},   64'(res_edges),   64'(e.edges));
                chk({tag, "_timeout"}, 64'(res_timeout), 64'(e.to));
            end
            tick();
        end
    endtask

    initial begin
        int   w;
        logic got;
        logic seen;
        rst_n        = 1'b0;
        enable       = 1'b0;
        sensor_in    = '0;
        cfg_n_cycles = 16'd4;
        cfg_timeout  = '0;
        res_ready    = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_valid",   64'(res_valid),   64'd0);
        chk("rst_ch",      64'(res_ch),      64'd0);
        chk("rst_coarse",  64'(res_coarse),  64'd0);
        chk("rst_edges",   64'(res_edges),   64'd0);
        chk("rst_timeout", 64'(res_timeout), 64'd0);
        chk("rst_busy",    64'(ch_busy),     64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (3) tick();

        // Single channel, N=4, period 10
        train(4'b0001, 10, 4);
        push(0, 30, 4, 0);
        wait_result("t1", 50, w);
        sensor_in = '0;

        // Fresh reset so the pointer starts at 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // All four stop together: order 0,1,2,3 back to back
        train(4'b1111, 10, 4);
        for (int i = 0; i < 4; i++) push(i, 30, 4, 0);
        wait_result("t2a0", 50, w);
        for (int i = 1; i < 4; i++) begin
            wait_result("t2a", 50, w);
            chk("t2a_b2b", 64'(w), 64'd0);
        end
        sensor_in = '0;
        repeat (3) tick();

        // Move the pointer to 2 via a single ch1 result, then all four: 2,3,0,1
        train(4'b0010, 10, 4);
        push(1, 30, 4, 0);
        wait_result("t2p", 50, w);
        sensor_in = '0;
        repeat (3) tick();
        train(4'b1111, 10, 4);
        push(2, 30, 4, 0);
        push(3, 30, 4, 0);
        push(0, 30, 4, 0);
        push(1, 30, 4, 0);
        wait_result("t2b0", 50, w);
        for (int i = 1; i < 4; i++) begin
            wait_result("t2b", 50, w);
            chk("t2b_b2b", 64'(w), 64'd0);
        end
        sensor_in = '0;
        repeat (3) tick();

        // Timeout: ch1 stalls after 3 edges
        cfg_timeout = 24'd100;
        train(4'b0010, 10, 3);
        push(1, 100, 3, 1);
        wait_result("t3", 200, w);
        sensor_in   = '0;
        cfg_timeout = '0;
        repeat (3) tick();

        // Backpressure: ch2 and ch3 finish while the consumer stalls (pointer is 2)
        res_ready = 1'b0;
        train(4'b1100, 10, 4);
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("t4_valid_rise", 64'(got), 64'd1);
        for (int c = 0; c < 20; c++) begin
            chk("t4_stable", 64'({res_valid, res_ch, res_coarse, res_edges, res_timeout}),
                64'({1'b1, 2'd2, 24'd30, 16'd4, 1'b0}));
            if (c == 5) sensor_in = sensor_in & ~4'b1100;
            if (c == 8) sensor_in = sensor_in | 4'b1000;
            tick();
        end
        // ch3 is still holding, so the edge above must not have restarted it
        chk("t4_hold_ignores_edge", 64'(ch_busy), 64'd0);
        res_ready = 1'b1;
        push(2, 30, 4, 0);
        push(3, 30, 4, 0);
        wait_result("t4a", 5, w);
        wait_result("t4b", 5, w);
        chk("t4_b2b", 64'(w), 64'd0);
        // After its grant ch3 re-arms and starts on a new edge
        sensor_in = sensor_in & ~4'b1000;
        repeat (2) tick();
        sensor_in = sensor_in | 4'b1000;
        repeat (6) tick();
        chk("t4_rearm_busy", 64'(ch_busy), 64'b1000);

        // Abort by enable drop mid-measure
        enable = 1'b0;
        tick();
        chk("t6_abort_busy", 64'(ch_busy), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) seen = 1'b1;
            tick();
        end
        chk("t6_abort_no_result", 64'(seen), 64'd0);
        enable    = 1'b1;
        sensor_in = '0;
        repeat (3) tick();

        // N promotion: cfg_n 0 and 1 behave as 2
        cfg_n_cycles = 16'd0;
        train(4'b0001, 7, 2);
        push(0, 7, 2, 0);
        wait_result("t5n0", 50, w);
        sensor_in = '0;
        repeat (3) tick();
        cfg_n_cycles = 16'd1;
        train(4'b0010, 7, 2);
        push(1, 7, 2, 0);
        wait_result("t5n1", 50, w);
        sensor_in = '0;
        repeat (3) tick();

        // N latched at start: 3 used even though cfg changes to 8 mid-measure
        cfg_n_cycles = 16'd3;
        sensor_in    = sensor_in | 4'b0100;
        gap(4'b0100, 7);
        cfg_n_cycles = 16'd8;
        train(4'b0100, 7, 2);
        push(2, 14, 3, 0);
        wait_result("t5latch", 50, w);
        sensor_in    = '0;
        cfg_n_cycles = 16'd4;
        repeat (3) tick();

        // Async reset while a result waits in the output register
        res_ready    = 1'b0;
        cfg_n_cycles = 16'd2;
        train(4'b0001, 7, 2);
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_pre_reset_valid", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_arst_valid",   64'(res_valid),   64'd0);
        chk("t6_arst_ch",      64'(res_ch),      64'd0);
        chk("t6_arst_coarse",  64'(res_coarse),  64'd0);
        chk("t6_arst_edges",   64'(res_edges),   64'd0);
        chk("t6_arst_timeout", 64'(res_timeout), 64'd0);
        chk("t6_arst_busy",    64'(ch_busy),     64'd0);
        tick();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        sensor_in = '0;
        repeat (3) tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
